// File: rtl/program_memory_arbiter.sv
// -----------------------------------------------------------------------------
// program_memory_arbiter
//
// Shares the single combinational Program_Memory read port between the
// instruction-fetch requester (F) and the data/debug read requester (D).
// Grants are combinational. Each accepted request returns a registered
// {valid, data, err} response on the following cycle. An address is legal
// when it is word aligned and lies inside the text segment
// [BASE_ADDR, BASE_ADDR + 4*MEMORY_DEPTH - 1]. Illegal accesses answer with
// data = 0 and err = 1.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> conflicts alternate between F and D
//                       undefined -> fixed priority, F always wins a conflict
//
// Parameters:
//   MEMORY_DEPTH   ROM depth in words (must match Program_Memory)
//   DATA_WIDTH     address and data width
//   BASE_ADDR      logical start address of the text segment
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   f_req_i / f_addr_i  fetch request and byte address (held until granted)
//   f_gnt_o             combinational grant to F
//   f_valid_o           one-cycle response strobe for F
//   f_data_o / f_err_o  F response word and error flag
//   d_*                 same set for the D requester
//   mem_address_o       logical address to Program_Memory address_i
//   mem_instruction_i   Program_Memory instruction_o
//   conflict_count_o    saturating count of cycles with both requests high
// -----------------------------------------------------------------------------
module program_memory_arbiter #(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  f_req_i,
  input  logic [DATA_WIDTH-1:0] f_addr_i,
  output logic                  f_gnt_o,
  output logic                  f_valid_o,
  output logic [DATA_WIDTH-1:0] f_data_o,
  output logic                  f_err_o,

  input  logic                  d_req_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  output logic                  d_gnt_o,
  output logic                  d_valid_o,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_err_o,

  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,

  output logic [15:0]           conflict_count_o
);

  // ---------------------------------------------------------------------------
  // Text-segment bounds, kept one bit wider than the bus so that a segment
  // ending at the top of the address space cannot wrap the upper bound.
  // ---------------------------------------------------------------------------
  localparam logic [DATA_WIDTH:0] ONE     = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] SPAN    = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH:0] ADDR_HI = ADDR_LO + SPAN - ONE;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rsp_t;

  function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH:0] wide;
    wide = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (wide >= ADDR_LO) && (wide <= ADDR_HI);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic both_req;
  logic f_wins_conflict;
  logic f_gnt;
  logic d_gnt;

  assign both_req = f_req_i & d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // last_winner: 0 = F won the previous conflict, 1 = D won it. Reset to D
  // so that F takes the first conflict after reset.
  logic last_winner_q;
  logic last_winner_d;

  assign f_wins_conflict = last_winner_q;

  always_comb begin
    last_winner_d = last_winner_q;
    if (both_req) begin
      last_winner_d = d_gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  // Fixed priority: the pointer would never leave its reset value, so no
  // state is kept and F simply wins every conflict.
  assign f_wins_conflict = 1'b1;
`endif

  // The loser of a conflict sees no grant; a lone requester always wins.
  assign f_gnt = f_req_i & (~d_req_i | f_wins_conflict);
  assign d_gnt = d_req_i & ~f_gnt;

  assign f_gnt_o = f_gnt;
  assign d_gnt_o = d_gnt;

  // ---------------------------------------------------------------------------
  // Memory address mux. The logical address is passed straight through;
  // Program_Memory does its own base subtraction and word indexing.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sel_addr;
  logic                  sel_legal;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    sel_addr = BASE_ADDR;
    if (f_gnt) begin
      sel_addr = f_addr_i;
    end else if (d_gnt) begin
      sel_addr = d_addr_i;
    end
  end

  assign mem_address_o = sel_addr;
  assign sel_legal     = addr_legal(sel_addr);
  // Memory data is discarded for illegal accesses.
  assign sel_data      = sel_legal ? mem_instruction_i : '0;

  // ---------------------------------------------------------------------------
  // Response registers. data/err keep their last value between responses;
  // only valid is a strobe.
  // ---------------------------------------------------------------------------
  rsp_t f_rsp_q, f_rsp_d;
  rsp_t d_rsp_q, d_rsp_d;

  always_comb begin
    f_rsp_d       = f_rsp_q;
    f_rsp_d.valid = 1'b0;
    if (f_gnt) begin
      f_rsp_d.valid = 1'b1;
      f_rsp_d.data  = sel_data;
      f_rsp_d.err   = ~sel_legal;
    end
  end

  always_comb begin
    d_rsp_d       = d_rsp_q;
    d_rsp_d.valid = 1'b0;
    if (d_gnt) begin
      d_rsp_d.valid = 1'b1;
      d_rsp_d.data  = sel_data;
      d_rsp_d.err   = ~sel_legal;
    end
  end

  // ---------------------------------------------------------------------------
  // Conflict counter, saturating at all ones.
  // ---------------------------------------------------------------------------
  logic [15:0] conflict_count_q;
  logic [15:0] conflict_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (both_req && (conflict_count_q != 16'hFFFF)) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end
  end

  // NOTE: reset clears every register here, so an access accepted just before
  // reset never produces a valid pulse; state updates use non-blocking
  // assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rsp_q          <= '0;
      d_rsp_q          <= '0;
      conflict_count_q <= '0;
    end else begin
      f_rsp_q          <= f_rsp_d;
      d_rsp_q          <= d_rsp_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign f_valid_o        = f_rsp_q.valid;
  assign f_data_o         = f_rsp_q.data;
  assign f_err_o          = f_rsp_q.err;
  assign d_valid_o        = d_rsp_q.valid;
  assign d_data_o         = d_rsp_q.data;
  assign d_err_o          = d_rsp_q.err;
  assign conflict_count_o = conflict_count_q;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_program_memory_arbiter
//
// Self-checking bench for program_memory_arbiter. A ROM array stands in for
// Program_Memory. A behavioural model derives expected grants, responses and
// the conflict count from the arbitration rules; a compare process checks the
// DUT against it every cycle, and directed phases add literal expectations.
// Build with or without ARB_ROUND_ROBIN_EN; the bench follows the macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_memory_arbiter;

  localparam int          DEPTH = 32;
  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_req_i, d_req_i;
  logic [DW-1:0] f_addr_i, d_addr_i;
  logic          f_gnt_o, f_valid_o, f_err_o;
  logic          d_gnt_o, d_valid_o, d_err_o;
  logic [DW-1:0] f_data_o, d_data_o;
  logic [DW-1:0] mem_address_o, mem_instruction_i;
  logic [15:0]   conflict_count_o;

  program_memory_arbiter #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (DW),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .f_req_i          (f_req_i),
    .f_addr_i         (f_addr_i),
    .f_gnt_o          (f_gnt_o),
    .f_valid_o        (f_valid_o),
    .f_data_o         (f_data_o),
    .f_err_o          (f_err_o),
    .d_req_i          (d_req_i),
    .d_addr_i         (d_addr_i),
    .d_gnt_o          (d_gnt_o),
    .d_valid_o        (d_valid_o),
    .d_data_o         (d_data_o),
    .d_err_o          (d_err_o),
    .mem_address_o    (mem_address_o),
    .mem_instruction_i(mem_instruction_i),
    .conflict_count_o (conflict_count_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Program ROM stand-in: rom[i] = A500_0000 + 0x11*i, except rom[1].
  // Outside the segment it returns a marker word that must never surface.
  // ---------------------------------------------------------------------------
  logic [31:0] rom [DEPTH];
  logic [31:0] rom_idx;

  assign rom_idx           = (mem_address_o - BASE) >> 2;
  assign mem_instruction_i = (mem_address_o >= BASE && rom_idx < DEPTH)
                             ? rom[rom_idx[4:0]] : 32'hDEAD_BEEF;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic bit legal(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a % 4 == 0) && (a >= longint'(BASE)) && (a <= longint'(BASE) + 4 * DEPTH - 1);
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] addr);
    return rom[(addr - BASE) / 4];
  endfunction

  // 0 = no grant, 1 = F, 2 = D. last = 1 means D won the previous conflict.
  function automatic int model_winner(input bit f, input bit d, input bit last);
    if (f && d) return last ? 1 : 2;
    if (f)      return 1;
    if (d)      return 2;
    return 0;
  endfunction

  bit          m_last;
  int          m_cnt;
  bit          ef_v, ed_v, ef_err, ed_err;
  logic [31:0] ef_data, ed_data;
  int          w_now;

  always_comb w_now = model_winner(f_req_i, d_req_i, m_last);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last  <= 1'b1;
      m_cnt   <= 0;
      ef_v    <= 1'b0;
      ed_v    <= 1'b0;
      ef_err  <= 1'b0;
      ed_err  <= 1'b0;
      ef_data <= '0;
      ed_data <= '0;
    end else begin
      ef_v <= (w_now == 1);
      ed_v <= (w_now == 2);
      if (w_now == 1) begin
        ef_err  <= !legal(f_addr_i);
        ef_data <= legal(f_addr_i) ? rom_at(f_addr_i) : 32'h0;
      end
      if (w_now == 2) begin
        ed_err  <= !legal(d_addr_i);
        ed_data <= legal(d_addr_i) ? rom_at(d_addr_i) : 32'h0;
      end
      if (f_req_i && d_req_i) begin
        if (m_cnt < 65535) m_cnt <= m_cnt + 1;
        if (RR_EN) m_last <= (w_now == 2);
      end
    end
  end

  // Compare process: outputs sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("f_gnt", {31'b0, f_gnt_o}, {31'b0, w_now == 1});
      check("d_gnt", {31'b0, d_gnt_o}, {31'b0, w_now == 2});
      check("mem_addr", mem_address_o,
            (w_now == 1) ? f_addr_i : (w_now == 2) ? d_addr_i : BASE);
      check("f_valid", {31'b0, f_valid_o}, {31'b0, ef_v});
      check("d_valid", {31'b0, d_valid_o}, {31'b0, ed_v});
      if (ef_v || reset) begin
        check("f_data", f_data_o, ef_data);
        check("f_err", {31'b0, f_err_o}, {31'b0, ef_err});
      end
      if (ed_v || reset) begin
        check("d_data", d_data_o, ed_data);
        check("d_err", {31'b0, d_err_o}, {31'b0, ed_err});
      end
      check("conflicts", {16'b0, conflict_count_o}, m_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req_i  = 1'b0;
    d_req_i  = 1'b0;
    f_addr_i = BASE;
    d_addr_i = BASE;
  endtask

  task automatic do_reset();
    step();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 4 * DEPTH;
      1:       return BASE - 4;
      2:       return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      3:       return $urandom;
      4:       return 32'hFFFF_FFFC;
      5:       return BASE + 4 * (DEPTH - 1);
      default: return BASE + 4 * $urandom_range(0, DEPTH - 1);
    endcase
  endfunction

  logic [31:0] stream_exp [4];
  bit          f_pend, d_pend;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA500_0000 + 32'h11 * i;
    rom[1] = 32'h2008_0005;
    stream_exp = '{32'hA500_0000, 32'h2008_0005, 32'hA500_0022, 32'hA500_0033};

    idle();
    #1 reset = 1'b1;
    step();
    step();
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    #2;
    check("rst_f_valid", {31'b0, f_valid_o}, 32'd0);
    check("rst_d_data", d_data_o, 32'd0);
    check("rst_conflicts", {16'b0, conflict_count_o}, 32'd0);

    // F alone, legal fetch of ROM[1]
    step();
    f_req_i  = 1'b1;
    f_addr_i = 32'h0040_0004;
    #2 check("t1_f_gnt", {31'b0, f_gnt_o}, 32'd1);
    step();
    idle();
    #2;
    check("t1_f_valid", {31'b0, f_valid_o}, 32'd1);
    check("t1_f_data", f_data_o, 32'h2008_0005);
    check("t1_f_err", {31'b0, f_err_o}, 32'd0);
    check("t1_d_valid", {31'b0, d_valid_o}, 32'd0);

    // D alone: misaligned, then one word past the segment end
    step();
    d_req_i  = 1'b1;
    d_addr_i = 32'h0040_0002;
    step();
    d_addr_i = 32'h0040_0080;
    #2;
    check("t2a_d_valid", {31'b0, d_valid_o}, 32'd1);
    check("t2a_d_err", {31'b0, d_err_o}, 32'd1);
    check("t2a_d_data", d_data_o, 32'd0);
    step();
    idle();
    #2;
    check("t2b_d_valid", {31'b0, d_valid_o}, 32'd1);
    check("t2b_d_err", {31'b0, d_err_o}, 32'd1);
    check("t2b_d_data", d_data_o, 32'd0);

    // Four consecutive conflicts from reset
    do_reset();
    f_req_i  = 1'b1;
    d_req_i  = 1'b1;
    f_addr_i = 32'h0040_0008;
    d_addr_i = 32'h0040_000C;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t3_f_gnt", {31'b0, f_gnt_o}, (RR_EN && i % 2 == 1) ? 32'd0 : 32'd1);
      check("t3_d_gnt", {31'b0, d_gnt_o}, (RR_EN && i % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    #2 check("t3_conflicts", {16'b0, conflict_count_o}, 32'd4);

    // F streaming ROM[0..3]
    step();
    f_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_addr_i = BASE + 4 * i;
      step();
      #2;
      check("t4_f_valid", {31'b0, f_valid_o}, 32'd1);
      check("t4_f_data", f_data_o, stream_exp[i]);
    end
    idle();

    // Reset right after an accept: the response must be swallowed
    step();
    f_req_i  = 1'b1;
    f_addr_i = BASE + 8;
    step();
    reset = 1'b1;
    idle();
    #1;
    check("t5_f_valid", {31'b0, f_valid_o}, 32'd0);
    check("t5_f_data", f_data_o, 32'd0);
    check("t5_conflicts", {16'b0, conflict_count_o}, 32'd0);
    step();
    step();
    reset   = 1'b0;
    f_req_i = 1'b1;
    d_req_i = 1'b1;
    #2;
    check("t5_first_f_gnt", {31'b0, f_gnt_o}, 32'd1);
    check("t5_first_d_gnt", {31'b0, d_gnt_o}, 32'd0);
    step();
    idle();
    step();

    // Randomized traffic; a requester holds req/addr until granted
    f_pend = 1'b0;
    d_pend = 1'b0;
    repeat (2000) begin
      if (!f_pend && $urandom_range(0, 2) != 0) begin
        f_pend   = 1'b1;
        f_addr_i = rand_addr();
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend   = 1'b1;
        d_addr_i = rand_addr();
      end
      f_req_i = f_pend;
      d_req_i = d_pend;
      #1;
      if (w_now == 1) f_pend = 1'b0;
      if (w_now == 2) d_pend = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1;
        f_pend = 1'b0;
        d_pend = 1'b0;
        idle();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    idle();

    // Counter saturation
    do_reset();
    f_req_i  = 1'b1;
    d_req_i  = 1'b1;
    f_addr_i = BASE;
    d_addr_i = BASE + 4;
    repeat (65540) step();
    #2 check("t6_saturated", {16'b0, conflict_count_o}, 32'h0000_FFFF);
    idle();
    step();
    step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_memory_arbiter.md
# program_memory_arbiter

Shares the single combinational Program_Memory read port between two requesters: the instruction-fetch port (F) and a data/debug read port (D, used by loads from the text segment and by the debug reader). Each granted request produces a registered response one cycle later, with an address-range and alignment check against the text segment. The block sits between the fetch stage / data-path load unit and the program ROM.

## Interface
- MEMORY_DEPTH, 32: ROM depth in words; must match the attached Program_Memory
- DATA_WIDTH, 32: address and data width
- BASE_ADDR, 32'h0040_0000: logical start address of the text segment

- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- f_req_i  input  1  fetch request; held with f_addr_i until granted
- f_addr_i  input  DATA_WIDTH  fetch logical byte address
- f_gnt_o  output  1  combinational grant to F; transfer occurs on the edge where f_req_i & f_gnt_o
- f_valid_o  output  1  one-cycle response strobe for F
- f_data_o  output  DATA_WIDTH  F response word
- f_err_o  output  1  F response error; qualified by f_valid_o
- d_req_i, d_addr_i, d_gnt_o, d_valid_o, d_data_o, d_err_o: same as F, for the D port
- mem_address_o  output  DATA_WIDTH  logical address to Program_Memory address_i
- mem_instruction_i  input  DATA_WIDTH  Program_Memory instruction_o
- conflict_count_o  output  16  saturating count of cycles with both requests high

## Operation
- At most one grant per cycle; a grant is issued only to an asserted request.
- Single requester: it is granted in the same cycle.
- Both requesting: the arbitration policy (see Configuration) selects one winner. The loser sees gnt=0 and must hold req/addr stable.
- mem_address_o = winner's address; BASE_ADDR when there is no grant. The logical address is passed through untranslated, because Program_Memory performs its own translation.
- Address legal iff addr[1:0]==0 and BASE_ADDR <= addr <= BASE_ADDR+4*MEMORY_DEPTH-1. Compare as unsigned DATA_WIDTH values; compute the upper bound in DATA_WIDTH+1 bits so it cannot wrap.
- Accepted legal request: on the next edge, register data = mem_instruction_i and err = 0.
- Accepted illegal request: register data = 0 and err = 1. The memory data is ignored.
- Response registers: {valid, data, err} per port. valid is high for exactly one cycle following acceptance.
- Back-to-back: a requester may raise a new request in the same cycle its valid is high. One accept per cycle gives a throughput of 1 word/cycle total.
- Priority state: a 1-bit pointer `last_winner` (F=0, D=1). It updates only on cycles where both requests are high.
- conflict_count_o increments on every cycle with f_req_i & d_req_i, independent of policy. It saturates at 16'hFFFF.

## Timing
- Grant: combinational from req inputs and the pointer; zero-cycle.
- Response latency: exactly 1 cycle from the accepting edge.
- Reset (asynchronous, any time): all valid=0, data=0, err=0, last_winner=1 (so F wins the first conflict), conflict_count_o=0.
- A request pending or accepted when reset asserts is dropped with no response. After release, requesters must re-issue.
- A request accepted in the cycle before reset asserts does not produce a valid pulse.
- gnt outputs are combinational and are not affected by the registered state other than the pointer. During reset, grants may still show combinationally, but no transfer is recorded.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a conflict the winner is the port that did not win the previous conflict, and last_winner toggles to that port.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, F always wins a conflict and D is granted only when f_req_i=0. The pointer is held at its reset value, and conflict_count_o still counts.

## Test plan
- Reset then F alone with f_addr_i=32'h0040_0004, ROM[1]=32'h2008_0005 -> f_gnt_o=1 same cycle; next cycle f_valid_o=1, f_data_o=32'h2008_0005, f_err_o=0; d_valid_o=0.
- D alone with d_addr_i=32'h0040_0002 (misaligned), then 32'h0040_0080 with MEMORY_DEPTH=32 (out of range) -> d_valid_o=1 with d_err_o=1 and d_data_o=0 each time.
- Both requesting continuously for 4 cycles, with round robin enabled -> winners F, D, F, D; conflict_count_o=4. With the macro undefined -> F wins all 4 and d_gnt_o stays 0.
- F streaming addresses 0x0040_0000, 4, 8, 0xC on consecutive cycles -> four consecutive f_valid_o pulses with ROM[0..3] in order.
- Assert reset mid-stream, one cycle after acceptance -> no valid pulse, all outputs 0. After release, the first conflict is won by F.
- Force 65 540 conflict cycles -> conflict_count_o holds at 16'hFFFF.
